// File: rtl/frame_engine_pkg.sv
// Shared types for the frame pixel engine: operation modes, FSM states and
// the read-pipeline sideband record.
package frame_engine_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ZERO = 2'd1,
    MODE_INV  = 2'd2,
    MODE_ADD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sideband_t;

endpackage

// File: rtl/frame_pixel_engine_pix_chan_op.sv
// Combinational per-channel transform; an unmasked channel passes unchanged.
module pix_chan_op
  import frame_engine_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  mode_e             i_mode,
  input  logic              i_en,
  input  logic [CH_W-1:0]   i_bias,
  input  logic [CH_W-1:0]   i_ch,
  output logic [CH_W-1:0]   o_ch
);

  logic [CH_W:0] w_sum;

  // One extra bit so the carry out of the addition drives saturation.
  assign w_sum = {1'b0, i_ch} + {1'b0, i_bias};

  // Select the transformed value for a masked channel.
  always_comb begin
    o_ch = i_ch;
    if (i_en) begin
      case (i_mode)
        MODE_PASS: o_ch = i_ch;
        MODE_ZERO: o_ch = {CH_W{1'b0}};
        MODE_INV:  o_ch = ~i_ch;
        MODE_ADD:  o_ch = w_sum[CH_W] ? {CH_W{1'b1}} : w_sum[CH_W-1:0];
        default:   o_ch = i_ch;
      endcase
    end else begin
      o_ch = i_ch;
    end
  end

endmodule

// File: rtl/frame_pixel_engine.sv
// Streaming read-process-write frame engine: one pixel per clock from a source
// buffer, per-channel operation, write to a strided destination buffer.
module frame_pixel_engine
  import frame_engine_pkg::*;
#(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 320,
  parameter int ADDR_W     = 32,
  parameter int CH_W       = 8,
  parameter int N_CH       = 3,
  parameter int RD_LAT     = 2,
  parameter int DST_STRIDE = 320
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [N_CH-1:0]   i_chan_mask,
  input  logic [CH_W-1:0]   i_bias,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic              i_hold,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_frame_end
);

  localparam int PIX_W = N_CH * CH_W;
  localparam int NPIX  = IMG_W * IMG_H;

  state_e             r_state;
  mode_e              r_mode;
  logic [N_CH-1:0]    r_mask;
  logic [CH_W-1:0]    r_bias;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_idx;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  sideband_t          r_sb [RD_LAT];
  logic               r_p_valid;
  logic [COORD_W-1:0] r_p_x;
  logic [COORD_W-1:0] r_p_y;
  logic [31:0]        r_p_data;
  logic [ADDR_W-1:0]  r_dst_row;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_frame_end;

  logic               w_accept;
  logic               w_last;
  logic               w_issue;
  logic               w_sb_any;
  logic               w_empty;
  logic [PIX_W-1:0]   w_proc;

  // A read is suppressed by hold, and by abort unless it is the final one.
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_idx == ADDR_W'(NPIX - 1));
  assign w_issue  = (r_state == S_RUN) && !i_hold && (!i_abort || w_last);
  assign w_empty  = !w_sb_any && !r_p_valid;

  assign o_rd_en     = w_issue;
  assign o_rd_addr   = r_src + r_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_end = r_frame_end;

  // Any read still travelling through the RAM latency window.
  always_comb begin
    w_sb_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_sb_any = w_sb_any | r_sb[i].valid;
    end
  end

  // Frame control FSM, configuration latch and read address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_PASS;
      r_mask  <= '0;
      r_bias  <= '0;
      r_src   <= '0;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode  <= mode_e'(i_mode);
            r_mask  <= i_chan_mask;
            r_bias  <= i_bias;
            r_src   <= i_src_base;
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_idx <= r_idx + ADDR_W'(1);
            if (r_x == COORD_W'(IMG_W - 1)) begin
              r_x <= '0;
              r_y <= r_y + COORD_W'(1);
            end else begin
              r_x <= r_x + COORD_W'(1);
            end
          end
          if (i_abort) begin
            r_error <= 1'b1;
            r_state <= S_DRAIN;
          end else if (w_issue && w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sideband delay line keeping pixel coordinates aligned with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      r_sb[0] <= '{valid: w_issue, x: r_x, y: r_y};
      for (int i = 1; i < RD_LAT; i++) begin
        r_sb[i] <= r_sb[i-1];
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    pix_chan_op #(.CH_W(CH_W)) u_op (
      .i_mode (r_mode),
      .i_en   (r_mask[c]),
      .i_bias (r_bias),
      .i_ch   (i_rd_data[c*CH_W +: CH_W]),
      .o_ch   (w_proc[c*CH_W +: CH_W])
    );
  end

  // Padding bits above the packed pixel are never processed.
  if (PIX_W < 32) begin : g_pad
    logic w_unused_rd_hi;
    assign w_unused_rd_hi = ^i_rd_data[31:PIX_W];
  end

  // Process stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_x     <= '0;
      r_p_y     <= '0;
      r_p_data  <= '0;
    end else begin
      r_p_valid <= r_sb[RD_LAT-1].valid;
      r_p_x     <= r_sb[RD_LAT-1].x;
      r_p_y     <= r_sb[RD_LAT-1].y;
      r_p_data  <= 32'(w_proc);
    end
  end

  // Write stage; pixels arrive in raster order so the row base just steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dst_row   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_wr_en     <= r_p_valid;
      r_frame_end <= r_p_valid && (r_p_x == COORD_W'(IMG_W - 1))
                               && (r_p_y == COORD_W'(IMG_H - 1));
      if (r_p_valid) begin
        r_wr_addr <= r_dst_row + ADDR_W'(r_p_x);
        r_wr_data <= r_p_data;
      end
      if (w_accept) begin
        r_dst_row <= i_dst_base;
      end else if (r_p_valid && (r_p_x == COORD_W'(IMG_W - 1))) begin
        r_dst_row <= r_dst_row + ADDR_W'(DST_STRIDE);
      end
    end
  end

endmodule

// File: tb/tb_frame_pixel_engine.sv
// Directed bench for frame_pixel_engine on a 4x2 frame with a 2-cycle RAM model.
module tb_frame_pixel_engine;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DST   = 8;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_hold, i_abort;
  logic [1:0]  i_mode;
  logic [2:0]  i_chan_mask;
  logic [7:0]  i_bias;
  logic [31:0] i_src_base, i_dst_base, i_rd_data;
  logic        o_rd_en, o_wr_en, o_busy, o_done, o_error, o_frame_end;
  logic [31:0] o_rd_addr, o_wr_addr, o_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  logic done_busy = 1'b0;
  int d0;

  int          rd_c[$];
  logic [31:0] rd_a[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        wf[$];
  int          wc[$];

  logic [31:0] ram_d1 = 32'h0;
  logic [31:0] ram_d2 = 32'h0;

  always #5 clk = ~clk;

  frame_pixel_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(32), .CH_W(8), .N_CH(3),
    .RD_LAT(LAT), .DST_STRIDE(DST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_chan_mask(i_chan_mask), .i_bias(i_bias), .i_src_base(i_src_base),
    .i_dst_base(i_dst_base), .i_hold(i_hold), .i_abort(i_abort),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_frame_end(o_frame_end)
  );

  // RAM model: word i holds 0x00102030+i, data valid two cycles after rd_en.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ram_d1 <= o_rd_en ? (32'h00102030 + o_rd_addr) : 32'h0;
    ram_d2 <= ram_d1;
  end
  assign i_rd_data = ram_d2;

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_en) begin
        rd_c.push_back(cyc);
        rd_a.push_back(o_rd_addr);
      end
      if (o_wr_en) begin
        wa.push_back(o_wr_addr);
        wd.push_back(o_wr_data);
        wf.push_back(o_frame_end);
        wc.push_back(cyc);
      end
      if (o_done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_err  <= o_error;
        done_busy <= o_busy;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int m, input logic [2:0] mask,
                                          input logic [7:0] b, input int i);
    logic [31:0] w;
    logic [31:0] r;
    int v;
    int o;
    w = 32'h00102030 + i;
    r = 32'h0;
    for (int c = 0; c < 3; c++) begin
      v = int'(w[c*8 +: 8]);
      o = v;
      if (mask[c]) begin
        case (m)
          1:       o = 0;
          2:       o = 255 - v;
          3:       o = (v + int'(b) > 255) ? 255 : v + int'(b);
          default: o = v;
        endcase
      end
      r[c*8 +: 8] = o[7:0];
    end
    return r;
  endfunction

  task automatic clear_logs();
    rd_c.delete(); rd_a.delete();
    wa.delete(); wd.delete(); wf.delete(); wc.delete();
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [2:0] mask, input logic [7:0] b);
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = m; i_chan_mask = mask; i_bias = b;
    i_src_base = 32'h0; i_dst_base = 32'h100;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_seen", {31'b0, n < 300}, 32'd1);
  endtask

  task automatic wait_reads(input int k);
    int n;
    n = 0;
    while (rd_c.size() < k && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("reads_seen", {31'b0, n < 100}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int m, input logic [2:0] mask,
                             input logic [7:0] b, input logic timed);
    int n;
    n = wa.size();
    check({tag, "_nwr"}, n, 32'd8);
    for (int i = 0; i < n && i < 8; i++) begin
      check({tag, "_addr"}, wa[i], 32'h100 + (i / IMG_W) * DST + (i % IMG_W));
      check({tag, "_data"}, wd[i], exp_pix(m, mask, b, i));
      check({tag, "_fend"}, {31'b0, wf[i]}, {31'b0, i == 7});
      if (timed) check({tag, "_b2b"}, wc[i], wc[0] + i);
    end
    if (timed && n > 0) check({tag, "_lat"}, wc[0] - rd_c[0], 32'd4);
    if (n > 0) check({tag, "_done_cyc"}, done_cyc, wc[n-1] + 1);
    check({tag, "_err"}, {31'b0, done_err}, 32'd0);
    check({tag, "_busy_at_done"}, {31'b0, done_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_hold = 1'b0; i_abort = 1'b0;
    i_mode = 2'd0; i_chan_mask = 3'd0; i_bias = 8'd0;
    i_src_base = 32'h0; i_dst_base = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", {31'b0, o_rd_en}, 32'd0);
    check("rst_wr_en", {31'b0, o_wr_en}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    check("rst_error", {31'b0, o_error}, 32'd0);
    check("rst_wr_addr", o_wr_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // pass, full mask
    clear_logs(); d0 = done_cnt;
    start_frame(2'd0, 3'b111, 8'h00);
    check("pass_busy", {31'b0, o_busy}, 32'd1);
    wait_done(d0);
    check_frame("pass", 0, 3'b111, 8'h00, 1'b1);
    check("pass_pix0", wd[0], 32'h00102030);
    check("pass_pix4_addr", wa[4], 32'h108);
    check("pass_last_addr", wa[7], 32'h10B);
    check("pass_rd7_addr", rd_a[7], 32'h7);

    // zero green channel
    clear_logs(); d0 = done_cnt;
    start_frame(2'd1, 3'b010, 8'h00);
    wait_done(d0);
    check_frame("zero", 1, 3'b010, 8'h00, 1'b1);
    check("zero_pix0", wd[0], 32'h00100030);

    // saturating add
    clear_logs(); d0 = done_cnt;
    start_frame(2'd3, 3'b111, 8'hF0);
    wait_done(d0);
    check_frame("add", 3, 3'b111, 8'hF0, 1'b1);
    check("add_pix0", wd[0], 32'h00FFFFFF);

    // invert red and blue
    clear_logs(); d0 = done_cnt;
    start_frame(2'd2, 3'b101, 8'h00);
    wait_done(d0);
    check_frame("inv", 2, 3'b101, 8'h00, 1'b1);
    check("inv_pix0", wd[0], 32'h00EF20CF);

    // hold for 3 cycles after 2 reads
    clear_logs(); d0 = done_cnt;
    start_frame(2'd0, 3'b111, 8'h00);
    wait_reads(2);
    i_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_rd", rd_c.size(), 32'd2);
    i_hold = 1'b0;
    wait_done(d0);
    check_frame("hold", 0, 3'b111, 8'h00, 1'b0);
    check("hold_nrd", rd_c.size(), 32'd8);

    // abort after 3 reads with a stray start
    clear_logs(); d0 = done_cnt;
    start_frame(2'd0, 3'b111, 8'h00);
    wait_reads(3);
    i_abort = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_start = 1'b0;
    wait_done(d0);
    check("abort_nwr", wa.size(), 32'd3);
    check("abort_nrd", rd_c.size(), 32'd3);
    check("abort_wr2_addr", wa[2], 32'h102);
    check("abort_done_err", {31'b0, done_err}, 32'd1);
    check("abort_err_hold", {31'b0, o_error}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_restart", wa.size(), 32'd3);
    check("abort_one_done", done_cnt, d0 + 1);
    check("abort_idle", {31'b0, o_busy}, 32'd0);

    // new start clears error
    clear_logs(); d0 = done_cnt;
    start_frame(2'd0, 3'b111, 8'h00);
    check("restart_err_clr", {31'b0, o_error}, 32'd0);
    wait_done(d0);
    check_frame("restart", 0, 3'b111, 8'h00, 1'b1);

    // reset mid-frame
    clear_logs();
    start_frame(2'd0, 3'b111, 8'h00);
    wait_reads(3);
    rst_n = 1'b0;
    #1;
    check("mrst_rd_en", {31'b0, o_rd_en}, 32'd0);
    check("mrst_wr_en", {31'b0, o_wr_en}, 32'd0);
    check("mrst_busy", {31'b0, o_busy}, 32'd0);
    check("mrst_wr_data", o_wr_data, 32'h0);
    check("mrst_rd_addr", o_rd_addr, 32'h0);
    clear_logs();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mrst_no_wr", wa.size(), 32'd0);
    check("mrst_no_rd", rd_c.size(), 32'd0);
    check("mrst_idle", {31'b0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_pixel_engine.md
Name: frame_pixel_engine

Overview:
- Parametrised read-process-write frame engine. Streams one pixel per clock from a source frame buffer in a dual-port RAM.
- Applies a per-channel operation selected per frame, then writes the result to a destination buffer with a configurable row stride.
- Sits between the command decoder and the frame RAM. Generalises the fixed 320x320, 4-cycle-per-pixel, green-only processing path with pipelined reads, hold/abort control and selectable modes.

Parameters:
- IMG_W, 320, pixels per row (>=2)
- IMG_H, 320, rows per frame (>=1)
- ADDR_W, 32, RAM address width
- CH_W, 8, bits per colour channel
- N_CH, 3, channels per pixel, packed LSB-first (ch0 = blue); N_CH*CH_W <= 32
- RD_LAT, 2, RAM read latency in cycles from rd_en to valid rd_data (>=1)
- DST_STRIDE, 320, destination words per row (>=IMG_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  begin frame; sampled only in IDLE
- mode  in  2  0=pass, 1=zero, 2=invert, 3=saturating add bias; latched at start
- chan_mask  in  N_CH  channels the mode applies to; latched at start
- bias  in  CH_W  addend for mode 3; latched at start
- src_base  in  ADDR_W  source frame base address; latched at start
- dst_base  in  ADDR_W  destination frame base address; latched at start
- hold  in  1  pause issuing reads
- abort  in  1  terminate frame early
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  32  RAM read data
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  32  RAM write data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at frame completion
- error  out  1  qualifies done; 1 = aborted frame
- frame_end  out  1  one-cycle pulse coincident with wr_en of the last pixel

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs 0, FSM in IDLE, counters and pipeline valid bits cleared. Reset mid-frame discards in-flight data; no further writes are issued.
- FSM IDLE -> RUN on start. RUN -> DRAIN when the last read is issued or abort=1. DRAIN -> DONE when the pipeline is empty. DONE -> IDLE after 1 cycle.
- start while not in IDLE is ignored. All configuration inputs are latched on the accepting cycle.
- RUN, hold=0: rd_en=1, rd_addr = src_base + idx. idx, x and y advance each cycle; x wraps at IMG_W-1 and y increments on wrap.
- RUN, hold=1: rd_en=0, counters frozen. In-flight reads still complete and write.
- Last read: idx == IMG_W*IMG_H-1.
- abort in RUN: no further reads, including in the abort cycle. In-flight pixels still write. done pulses with error=1. abort outside RUN is ignored. abort and the last read in the same cycle: the last read is issued and error=1.
- Sideband shift register, RD_LAT deep, carries {valid, x, y} aligned with rd_data.
- Process stage is registered: masked channels are transformed, unmasked channels pass through.
  - zero: channel -> 0
  - invert: channel -> ~channel
  - add: channel -> min(channel + bias, 2^CH_W - 1), computed CH_W+1 wide
  - Bits above N_CH*CH_W are written as 0.
- Write stage is registered:
  - wr_en = processed valid
  - wr_addr = dst_base + y*DST_STRIDE + x; the row base is maintained incrementally, no multiplier
  - wr_data = processed pixel
- Latency: wr_en is asserted exactly RD_LAT+2 cycles after its rd_en. With hold=0 throughout, a full frame gives IMG_W*IMG_H back-to-back writes.
- DRAIN exits when no sideband or process valid bit is set. done rises the cycle after the final write. busy falls together with the done pulse.
- error holds its value until the next accepted start.

Decomposition:
- Package frame_engine_pkg holds:
  - mode enum (MODE_PASS, MODE_ZERO, MODE_INV, MODE_ADD)
  - FSM state enum (S_IDLE, S_RUN, S_DRAIN, S_DONE)
  - sideband struct {valid, x, y}
- One sub-module: pix_chan_op, a combinational per-channel operation (mode, mask bit, bias, CH_W in, CH_W out), instantiated N_CH times via generate.

Test Plan (IMG_W=4, IMG_H=2, DST_STRIDE=8, RD_LAT=2, src_base=0, dst_base=0x100, RAM word i = 0x00102030+i):
- Pass mode, full mask -> 8 writes on consecutive cycles. First write is 4 cycles after the first rd_en, to 0x100 with 0x00102030. Pixel 4 goes to 0x108. Last write goes to 0x10B with frame_end=1. done=1, error=0 the next cycle.
- mode=1, mask=3'b010 -> every wr_data has bits[15:8]=0. Example: pixel 0 = 0x00100030.
- mode=3, bias=0xF0, mask=3'b111, pixel 0 -> ch2 0x10+0xF0 = 0xFF saturated (16+240=256 clips). ch1 = 0x20+0xF0 = 0xFF. ch0 = 0x30+0xF0 = 0xFF.
- hold=1 for 3 cycles after 2 reads -> the 2 in-flight pixels still write. No rd_en during hold. Resuming gives the same 8 addresses and data as the no-hold run.
- abort after 3 reads; start pulsed while busy -> exactly 3 writes, then done=1 with error=1. The extra start has no effect. A new start afterwards clears error.
- rst_n low mid-RUN -> all outputs 0 immediately. No wr_en after deassertion until the next start.
